// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS
// core. Owns the program counter, presents it to instruction memory, and
// captures the returned word together with its PC+4 into IF/ID.
//
// Each rising edge applies exactly one action, highest priority first:
//   REDIRECT  branch_taken     : load branch target, flush IF/ID to a bubble
//   STALL     hazard_detected  : hold PC and every IF/ID field
//   MISS      !imem_valid      : hold PC, push a bubble into IF/ID
//   ADVANCE   otherwise        : PC += 4, capture fetched word into IF/ID
//
// Parameters:
//   RESET_PC   PC loaded on reset
//   NOP_INSTR  word written into IF/ID for bubbles
//
// Ports:
//   clk, rst_n        clock (rising edge) and async active-low reset
//   hazard_detected   load-use stall request
//   branch_taken      redirect request
//   branch_target     redirect address (bits [1:0] ignored)
//   imem_addr         current PC, straight from the PC register
//   imem_rdata        instruction word at imem_addr (combinational read)
//   imem_valid        imem_rdata is valid this cycle
//   IFID_instr        registered instruction
//   IFID_pc_plus4     registered PC+4 of that instruction
//   IFID_valid        IF/ID holds a real instruction
//   IFID_reg_rs/rt    rs/rt fields of IFID_instr (not gated by IFID_valid)
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   perf_stall_cycles, perf_flush_count, perf_miss_cycles -- 32-bit
//   saturating event counters for STALL, REDIRECT and MISS cycles.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard_detected,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] IFID_instr,
  output logic [31:0] IFID_pc_plus4,
  output logic        IFID_valid,
  output logic [4:0]  IFID_reg_rs,
  output logic [4:0]  IFID_reg_rt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count,
  output logic [31:0] perf_miss_cycles
`endif
);

  typedef enum logic [1:0] {
    ACT_REDIRECT,
    ACT_STALL,
    ACT_MISS,
    ACT_ADVANCE
  } action_e;

  // The PC is kept word-aligned by construction: reset value and branch
  // targets are masked, and +4 never touches bits [1:0].
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  action_e     action;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  // Priority decode of the per-edge action.
  always_comb begin
    action = ACT_ADVANCE;
    if (branch_taken) begin
      action = ACT_REDIRECT;
    end else if (hazard_detected) begin
      action = ACT_STALL;
    end else if (!imem_valid) begin
      action = ACT_MISS;
    end
  end

  // Modulo-2^32 increment; 32'hFFFF_FFFC wraps to 0 silently.
  assign pc_plus4 = pc_q + 32'd4;

  // Next-state for the PC and the IF/ID register.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    unique case (action)
      ACT_REDIRECT: begin
        pc_d       = {branch_target[31:2], 2'b00};
        instr_d    = NOP_INSTR;
        pc_plus4_d = 32'd0;
        valid_d    = 1'b0;
      end
      ACT_STALL: begin
        // Everything holds.
      end
      ACT_MISS: begin
        instr_d    = NOP_INSTR;
        pc_plus4_d = 32'd0;
        valid_d    = 1'b0;
      end
      ACT_ADVANCE: begin
        pc_d       = pc_plus4;
        instr_d    = imem_rdata;
        pc_plus4_d = pc_plus4;
        valid_d    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC_ALIGNED;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_addr     = pc_q;
  assign IFID_instr    = instr_q;
  assign IFID_pc_plus4 = pc_plus4_q;
  assign IFID_valid    = valid_q;
  assign IFID_reg_rs   = instr_q[25:21];
  assign IFID_reg_rt   = instr_q[20:16];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] miss_cnt_q,  miss_cnt_d;

  // Each counter bumps at most once per edge and sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if ((action == ACT_STALL) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if ((action == ACT_REDIRECT) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
    if ((action == ACT_MISS) && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
      miss_cnt_q  <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flush_count  = flush_cnt_q;
  assign perf_miss_cycles  = miss_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. Instruction memory is modelled as
// word = addr | 32'hA000_0000 so every fetched word identifies its address.
// Inputs change on the falling edge and outputs are checked there, half a
// cycle away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        hazard_detected;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] IFID_instr;
  logic [31:0] IFID_pc_plus4;
  logic        IFID_valid;
  logic [4:0]  IFID_reg_rs;
  logic [4:0]  IFID_reg_rt;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
  logic [31:0] perf_miss_cycles;
`endif

  int checks;
  int failures;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hazard_detected(hazard_detected),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .IFID_instr     (IFID_instr),
    .IFID_pc_plus4  (IFID_pc_plus4),
    .IFID_valid     (IFID_valid),
    .IFID_reg_rs    (IFID_reg_rs),
    .IFID_reg_rt    (IFID_reg_rt)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_count (perf_flush_count),
    .perf_miss_cycles (perf_miss_cycles)
`endif
  );

  // Combinational instruction memory.
  assign imem_rdata = imem_addr | 32'hA000_0000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports one check.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  // Checks PC and the full IF/ID register at once.
  task automatic checkState(input string tag, input logic [31:0] exp_pc,
                            input logic [31:0] exp_instr,
                            input logic [31:0] exp_pc4, input logic exp_valid);
    checkOutput({tag, ".pc"},    imem_addr,            exp_pc);
    checkOutput({tag, ".instr"}, IFID_instr,           exp_instr);
    checkOutput({tag, ".pc4"},   IFID_pc_plus4,        exp_pc4);
    checkOutput({tag, ".valid"}, {31'd0, IFID_valid},  {31'd0, exp_valid});
  endtask

  // Drives inputs for the coming rising edge, lets it happen, and returns
  // at the following falling edge.
  task automatic applyStimulus(input logic hz, input logic bt,
                               input logic [31:0] tgt, input logic iv);
    hazard_detected = hz;
    branch_taken    = bt;
    branch_target   = tgt;
    imem_valid      = iv;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    hazard_detected = 1'b0;
    branch_taken    = 1'b0;
    branch_target   = 32'd0;
    imem_valid      = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    checkState("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    checkOutput("reset.rs", {27'd0, IFID_reg_rs}, 32'd0);
    checkOutput("reset.rt", {27'd0, IFID_reg_rt}, 32'd0);
    rst_n = 1'b1;

    // Free run: three edges
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkState("run1", 32'h4, 32'hA000_0000, 32'h4, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkState("run3", 32'hC, 32'hA000_0008, 32'hC, 1'b1);

    // Advance to pc=0x20
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkState("pre_stall", 32'h20, 32'hA000_001C, 32'h20, 1'b1);

    // Load-use stall, two cycles
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkState("stall1", 32'h20, 32'hA000_001C, 32'h20, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkState("stall2", 32'h20, 32'hA000_001C, 32'h20, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkState("post_stall", 32'h24, 32'hA000_0020, 32'h24, 1'b1);

    // Advance to pc=0x40, then one miss cycle
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkState("pre_miss", 32'h40, 32'hA000_003C, 32'h40, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkState("miss", 32'h40, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkState("post_miss", 32'h44, 32'hA000_0040, 32'h44, 1'b1);

    // Redirect with simultaneous stall and miss; low bits of target dropped
    applyStimulus(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    checkState("redirect", 32'h100, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkState("post_redirect", 32'h104, 32'hA000_0100, 32'h104, 1'b1);
    checkOutput("rs_decode", {27'd0, IFID_reg_rs}, 32'd0);

    // Wrap: redirect to top of memory, then advance past it
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    checkState("redirect_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkState("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);
    checkOutput("wrap.rs", {27'd0, IFID_reg_rs}, 32'd31);
    checkOutput("wrap.rt", {27'd0, IFID_reg_rt}, 32'd31);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkState("after_wrap", 32'h4, 32'hA000_0000, 32'h4, 1'b1);

    // Stall wins over a simultaneous miss
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkState("stall_over_miss", 32'h4, 32'hA000_0000, 32'h4, 1'b1);

`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf_stall", perf_stall_cycles, 32'd3);
    checkOutput("perf_flush", perf_flush_count,  32'd2);
    checkOutput("perf_miss",  perf_miss_cycles,  32'd1);
`endif

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkState("resume", 32'h8, 32'hA000_0004, 32'h8, 1'b1);

    // Asynchronous reset asserted mid-cycle, clock edge not awaited
    hazard_detected = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkState("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("async_reset.perf_stall", perf_stall_cycles, 32'd0);
    checkOutput("async_reset.perf_flush", perf_flush_count,  32'd0);
`endif
    hazard_detected = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkState("rerun", 32'h4, 32'hA000_0000, 32'h4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage 32-bit MIPS core. It owns the PC, drives the instruction-memory address and captures the fetched word into IF/ID. It also exposes the decoded rs/rt fields that feed the load-use hazard detection unit. It consumes that unit's `hazard_detected` as a stall, and the branch-resolution redirect as a flush.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0000 (sll $0,$0,0): word inserted into IF/ID for bubbles.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `hazard_detected` in 1: load-use stall request from the hazard detection unit.
- `branch_taken` in 1: redirect request from branch resolution.
- `branch_target` in 32: redirect address; bits [1:0] are ignored and forced to 0.
- `imem_addr` out 32: current PC, driven directly from the PC register.
- `imem_rdata` in 32: instruction word at `imem_addr`, combinational read.
- `imem_valid` in 1: `imem_rdata` is valid this cycle.
- `IFID_instr` out 32: registered instruction.
- `IFID_pc_plus4` out 32: registered PC+4 of that instruction.
- `IFID_valid` out 1: IF/ID holds a real instruction, not a bubble.
- `IFID_reg_rs` out 5: `IFID_instr[25:21]`, combinational from the register.
- `IFID_reg_rt` out 5: `IFID_instr[20:16]`, combinational from the register.

## Operation
Each rising edge applies exactly one of the following cases, in priority order:
1. **REDIRECT** (`branch_taken`=1):
   - pc <= {branch_target[31:2],2'b00}.
   - IF/ID flushed: instr <= NOP_INSTR, valid <= 0, pc_plus4 <= 0.
   - Overrides a simultaneous `hazard_detected` and a simultaneous `imem_valid`=0.
2. **STALL** (`hazard_detected`=1): pc and all IF/ID fields hold their values.
3. **MISS** (`imem_valid`=0):
   - pc holds.
   - IF/ID loads a bubble (NOP_INSTR, valid 0, pc_plus4 0) so downstream stages keep draining.
4. **ADVANCE**:
   - pc <= pc+4.
   - IF/ID <= {imem_rdata, pc+4, valid 1}.

Rules common to all cases:
- Arithmetic: pc+4 is a 32-bit modulo add; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- PC bits [1:0] are always 0.
- The rs/rt outputs of a bubble are decoded from NOP_INSTR, i.e. 0 with the default. Gating those against `IFID_valid` is the consumer's concern; this block does not gate them.

## Timing
- Reset (asynchronous assert, release synchronized by the system):
  - pc = RESET_PC, so `imem_addr` = RESET_PC.
  - `IFID_instr` = NOP_INSTR, `IFID_pc_plus4` = 0, `IFID_valid` = 0.
  - `IFID_reg_rs` and `IFID_reg_rt` = the NOP fields (0).
  - All counters = 0.
- Reset asserted mid-stall or mid-redirect discards the pending state immediately.
- `imem_addr` changes only on a clock edge; `imem_rdata` must settle within the same cycle.
- Fetch-to-IF/ID latency is 1 cycle: the word fetched at edge N is visible on the IF/ID outputs after edge N.
- The first cycle after reset release fetches RESET_PC; the first valid IF/ID appears after the next edge.
- A branch target is fetched in the cycle after `branch_taken`. Exactly one bubble enters IF/ID per redirect.
- STALL of k cycles keeps `IFID_*` stable for k cycles; the next ADVANCE resumes at the held pc.
- `hazard_detected` is sampled only at the edge and may arrive late in the cycle; it is not used combinationally toward any output.

## Configuration
- `FETCH_PERF_CNT_EN` defined adds three outputs, each 32 bits, incrementing at most once per edge and saturating at 32'hFFFF_FFFF:
  - `perf_stall_cycles`: counts STALL cycles.
  - `perf_flush_count`: counts REDIRECT cycles.
  - `perf_miss_cycles`: counts MISS cycles.
  - All three reset to 0.
- `FETCH_PERF_CNT_EN` undefined: these ports and their registers do not exist; all other behaviour is identical.

## Test plan
- **Reset, then free run:** RESET_PC=0, imem returns word = addr|32'hA000_0000.
  - Required: after 3 edges, pc=12, `IFID_instr`=32'hA000_0008, `IFID_pc_plus4`=12, valid=1.
- **Load-use stall:** `hazard_detected`=1 for 2 cycles while pc=0x20.
  - Required: pc stays 0x20 and `IFID_*` is unchanged for both cycles.
  - Required: the next ADVANCE captures word@0x20 and pc becomes 0x24.
- **Redirect with simultaneous stall:** `branch_taken`=1, target=0x103, `hazard_detected`=1.
  - Required: pc=0x100, `IFID_valid`=0, `IFID_instr`=NOP.
  - Required: the next edge captures word@0x100.
- **Memory miss:** `imem_valid`=0 for 1 cycle at pc=0x40.
  - Required: one bubble in IF/ID and pc holds 0x40.
  - Required: the next edge loads word@0x40 with valid=1.
- **Wrap and reset:**
  - pc=0xFFFF_FFFC then ADVANCE -> pc=0.
  - Assert `rst_n` low mid-cycle -> immediately pc=RESET_PC and `IFID_valid`=0, without waiting for a clock edge.
- **FETCH_PERF_CNT_EN:** 3 stall cycles, 2 redirects and 1 miss -> counters read 3, 2 and 1.
